uart_debug_ctrl: RTL and testbench

- Command-driven debug controller between the UART receiver, the tx character FIFO and the pipeline.
- Decodes received command bytes to single-step, free-run or halt the pipeline.
- Serialises a parametrised set of pipeline debug words into the tx FIFO, one byte per write.
- Generalises the single-step/PC dump flow to N words of configurable width, with a run mode, a header byte and FIFO back-pressure.

---
 rtl/uart_debug_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_debug_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_ctrl.sv
// UART-driven debug controller: decodes step/run/halt/dump commands, gates the
// pipeline clock and streams a frozen snapshot of the debug words into the tx FIFO.
module uart_debug_ctrl #(
    parameter int         NUM_WORDS  = 8,
    parameter int         WORD_BYTES = 4,
    parameter int         SETTLE_CYC = 2,
    parameter logic [7:0] DUMP_HDR   = 8'h42,
    parameter logic [7:0] CMD_STEP   = 8'h41,
    parameter logic [7:0] CMD_RUN    = 8'h52,
    parameter logic [7:0] CMD_HALT   = 8'h48,
    parameter logic [7:0] CMD_DUMP   = 8'h44
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_data_rdy,
    input  logic [NUM_WORDS*WORD_BYTES*8-1:0]   dbg_words,
    input  logic                                pipe_done,
    input  logic                                fifo_full,
    output logic [7:0]                          fifo_din,
    output logic                                fifo_wr_en,
    output logic                                pipe_clk_en,
    output logic                                busy,
    output logic                                cmd_err
);

    localparam int TOTAL_BITS = NUM_WORDS * WORD_BYTES * 8;
    localparam int BYTE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WORD_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SET_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(WORD_BYTES - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_SETTLE, S_SNAP, S_HDR, S_DUMP, S_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_rdy_q, rx_rdy_d;
    logic [SET_W-1:0]        settle_cnt_q, settle_cnt_d;
    logic [BYTE_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]       word_cnt_q, word_cnt_d;
    logic [TOTAL_BITS-1:0]   snap_q, snap_d;

    logic                    cmd_fire;
    logic [31:0]             dump_shift;

    // Only a fresh rising edge of the receiver's valid counts as a command.
    assign cmd_fire   = rx_data_rdy & ~rx_rdy_q & ~rst;
    assign dump_shift = (32'(word_cnt_q) * 32'(WORD_BYTES) + 32'(byte_cnt_q)) << 3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_rdy_q     <= 1'b0;
            settle_cnt_q <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            rx_rdy_q     <= rx_rdy_d;
            settle_cnt_q <= settle_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            snap_q       <= snap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rx_rdy_d     = rx_data_rdy;
        settle_cnt_d = settle_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        snap_d       = snap_q;
        fifo_din     = 8'h00;
        fifo_wr_en   = 1'b0;
        pipe_clk_en  = 1'b0;
        cmd_err      = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (rx_data)
                        CMD_STEP: state_d = S_STEP;
                        CMD_RUN:  state_d = S_RUN;
                        CMD_DUMP: state_d = S_SNAP;
                        CMD_HALT: state_d = S_IDLE;
                        default:  cmd_err = 1'b1;
                    endcase
                end
            end
            S_STEP: begin
                pipe_clk_en = 1'b1;
                cmd_err     = cmd_fire;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                cmd_err = cmd_fire;
                if (settle_cnt_q == SET_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = S_SNAP;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_SNAP: begin
                cmd_err = cmd_fire;
                snap_d  = dbg_words;
                state_d = S_HDR;
            end
            S_HDR: begin
                cmd_err  = cmd_fire;
                fifo_din = DUMP_HDR;
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    state_d    = S_DUMP;
                end
            end
            S_DUMP: begin
                cmd_err  = cmd_fire;
                fifo_din = 8'(snap_q >> dump_shift);
                // Counters only advance on an accepted byte, so back-pressure never drops or repeats data.
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d = '0;
                        if (word_cnt_q == WORD_LAST) begin
                            word_cnt_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                pipe_clk_en = 1'b1;
                if (cmd_fire && (rx_data != CMD_HALT) && (rx_data != CMD_RUN)) begin
                    cmd_err = 1'b1;
                end
                // A halt command and pipe_done together still make a single transition.
                if ((cmd_fire && (rx_data == CMD_HALT)) || pipe_done) begin
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Directed self-checking bench for uart_debug_ctrl (NUM_WORDS=8, WORD_BYTES=4, SETTLE_CYC=2).
module tb_uart_debug_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_data_rdy;
    logic [255:0] dbg_words;
    logic         pipe_done;
    logic         fifo_full;
    logic [7:0]   fifo_din;
    logic         fifo_wr_en;
    logic         pipe_clk_en;
    logic         busy;
    logic         cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc = 0;
    logic [7:0] wr_log[$];
    int   wr_cyc[$];
    int   pipe_hi = 0;
    int   pipe_rise = 0;
    int   err_cnt = 0;
    int   full_viol = 0;
    logic pipe_prev = 1'b0;

    int cmd_cyc;

    uart_debug_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_data_rdy(rx_data_rdy),
        .dbg_words  (dbg_words),
        .pipe_done  (pipe_done),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .pipe_clk_en(pipe_clk_en),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer on the falling edge: records every accepted FIFO write and pipeline/err activity.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            wr_log.push_back(fifo_din);
            wr_cyc.push_back(cyc);
            if (fifo_full !== 1'b0) full_viol = full_viol + 1;
        end
        if (pipe_clk_en === 1'b1) pipe_hi = pipe_hi + 1;
        if (pipe_clk_en === 1'b1 && pipe_prev !== 1'b1) pipe_rise = pipe_rise + 1;
        pipe_prev = pipe_clk_en;
        if (cmd_err === 1'b1) err_cnt = err_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Raises rx_data_rdy with the given byte for 'hold' cycles; called at posedge+1.
    task automatic applyStimulus(input logic [7:0] cmd, input int hold);
        cmd_cyc     = cyc;
        rx_data     = cmd;
        rx_data_rdy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_data_rdy = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) break;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        if (wr_cyc.size() > 0) checkOutput({tag, "_busy_drop"}, cyc - wr_cyc[wr_cyc.size()-1], 32'd1);
    endtask

    task automatic waitWrites(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (wr_log.size() >= target) break;
            @(posedge clk);
            #1;
        end
        checkOutput("wait_writes", 32'(wr_log.size() >= target), 32'd1);
    endtask

    function automatic logic [7:0] expByte(input logic [255:0] d, input int j);
        if (j == 0) return 8'h42;
        return 8'(d >> ((j - 1) * 8));
    endfunction

    task automatic checkDump(input string tag, input int base, input logic [255:0] d);
        checkOutput({tag, "_len"}, wr_log.size() - base, 32'd33);
        for (int j = 0; j < 33; j++) begin
            if (base + j < wr_log.size())
                checkOutput($sformatf("%s_byte%0d", tag, j), 32'(wr_log[base+j]), 32'(expByte(d, j)));
        end
    endtask

    initial begin
        logic [7:0]   hand_t1 [9];
        logic [255:0] d1;
        int base, pr0, ph0, er0, fv0, n_at_rst;

        hand_t1 = '{8'h42, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h20};
        d1 = '0;
        d1[31:0]  = 32'h0000_0004;
        d1[63:32] = 32'h2000_0001;

        rst = 1'b1; rx_data = 8'h00; rx_data_rdy = 1'b0; dbg_words = d1;
        pipe_done = 1'b0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        checkOutput("rst_din", 32'(fifo_din), 32'd0);
        checkOutput("rst_clk_en", 32'(pipe_clk_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single step dump");
        base = wr_log.size(); pr0 = pipe_rise; ph0 = pipe_hi; er0 = err_cnt; fv0 = full_viol;
        applyStimulus(8'h41, 1);
        waitWrites(base + 1, 20);
        dbg_words = {8{32'hFFFF_FFFF}};
        waitIdle("t1", 80);
        // Detect, STEP, two SETTLE, SNAP, HDR: the header write sits five cycles after the command cycle.
        checkOutput("t1_latency", wr_cyc[base] - cmd_cyc, 32'd5);
        checkOutput("t1_len", wr_log.size() - base, 32'd33);
        for (int j = 0; j < 33; j++) begin
            if (base + j < wr_log.size())
                checkOutput($sformatf("t1_byte%0d", j), 32'(wr_log[base+j]), 32'(j < 9 ? hand_t1[j] : 8'h00));
        end
        checkOutput("t1_pulses", pipe_rise - pr0, 32'd1);
        checkOutput("t1_hi_cycles", pipe_hi - ph0, 32'd1);
        checkOutput("t1_err", err_cnt - er0, 32'd0);
        dbg_words = d1;

        $display("[TB] step with fifo back-pressure");
        base = wr_log.size(); pr0 = pipe_rise;
        applyStimulus(8'h41, 1);
        waitWrites(base + 3, 30);
        fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 fifo_full = 1'b0;
        waitIdle("t2", 80);
        checkDump("t2", base, d1);
        checkOutput("t2_pulses", pipe_rise - pr0, 32'd1);
        checkOutput("t2_wr_while_full", full_viol - fv0, 32'd0);

        $display("[TB] held rx_data_rdy");
        base = wr_log.size(); pr0 = pipe_rise; er0 = err_cnt;
        applyStimulus(8'h41, 20);
        waitIdle("t3", 80);
        repeat (10) @(posedge clk);
        #1;
        checkDump("t3", base, d1);
        checkOutput("t3_pulses", pipe_rise - pr0, 32'd1);
        checkOutput("t3_err", err_cnt - er0, 32'd0);

        $display("[TB] run then halt command");
        base = wr_log.size(); pr0 = pipe_rise; ph0 = pipe_hi;
        applyStimulus(8'h52, 1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("run_clk_en", 32'(pipe_clk_en), 32'd1);
        checkOutput("run_busy", 32'(busy), 32'd1);
        applyStimulus(8'h48, 1);
        waitIdle("t4a", 80);
        checkDump("t4a", base, d1);
        // RUN lasts from the edge after the R command through the edge after H: 11 cycles.
        checkOutput("t4a_hi_cycles", pipe_hi - ph0, 32'd11);
        checkOutput("t4a_pulses", pipe_rise - pr0, 32'd1);

        $display("[TB] run then pipe_done");
        base = wr_log.size(); pr0 = pipe_rise; ph0 = pipe_hi;
        applyStimulus(8'h52, 1);
        repeat (10) @(posedge clk);
        #1 pipe_done = 1'b1;
        @(posedge clk);
        #1 pipe_done = 1'b0;
        waitIdle("t4b", 80);
        checkDump("t4b", base, d1);
        checkOutput("t4b_hi_cycles", pipe_hi - ph0, 32'd11);
        checkOutput("t4b_pulses", pipe_rise - pr0, 32'd1);

        $display("[TB] halt and pipe_done together");
        base = wr_log.size(); er0 = err_cnt;
        applyStimulus(8'h52, 1);
        repeat (5) @(posedge clk);
        #1;
        rx_data = 8'h48; rx_data_rdy = 1'b1; pipe_done = 1'b1;
        @(posedge clk);
        #1 rx_data_rdy = 1'b0; pipe_done = 1'b0;
        waitIdle("t4c", 80);
        repeat (50) @(posedge clk);
        #1;
        checkDump("t4c", base, d1);
        checkOutput("t4c_busy_after", 32'(busy), 32'd0);
        checkOutput("t4c_err", err_cnt - er0, 32'd0);

        $display("[TB] command during dump and unknown command");
        base = wr_log.size(); pr0 = pipe_rise; er0 = err_cnt;
        applyStimulus(8'h41, 1);
        waitWrites(base + 5, 30);
        applyStimulus(8'h41, 1);
        waitIdle("t5", 80);
        checkDump("t5", base, d1);
        checkOutput("t5_pulses", pipe_rise - pr0, 32'd1);
        checkOutput("t5_err", err_cnt - er0, 32'd1);
        base = wr_log.size(); pr0 = pipe_rise; er0 = err_cnt;
        applyStimulus(8'h5A, 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t5_unk_err", err_cnt - er0, 32'd1);
        checkOutput("t5_unk_busy", 32'(busy), 32'd0);
        checkOutput("t5_unk_writes", wr_log.size() - base, 32'd0);
        er0 = err_cnt;
        applyStimulus(8'h48, 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t5_halt_idle_err", err_cnt - er0, 32'd0);
        checkOutput("t5_halt_idle_busy", 32'(busy), 32'd0);
        checkOutput("t5_pulses_after", pipe_rise - pr0, 32'd0);

        $display("[TB] reset mid-dump");
        base = wr_log.size();
        applyStimulus(8'h41, 1);
        waitWrites(base + 10, 40);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_at_rst = wr_log.size();
        checkOutput("t6_wr_en", 32'(fifo_wr_en), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_din", 32'(fifo_din), 32'd0);
        checkOutput("t6_clk_en", 32'(pipe_clk_en), 32'd0);
        for (int j = 0; j < n_at_rst - base; j++)
            checkOutput($sformatf("t6_prefix%0d", j), 32'(wr_log[base+j]), 32'(expByte(d1, j)));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t6_no_more_writes", wr_log.size(), n_at_rst);

        $display("[TB] dump-only after reset");
        base = wr_log.size(); pr0 = pipe_rise; fv0 = full_viol;
        applyStimulus(8'h44, 1);
        waitIdle("t7", 80);
        checkDump("t7", base, d1);
        checkOutput("t7_pulses", pipe_rise - pr0, 32'd0);
        checkOutput("t7_wr_while_full", full_viol - fv0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
